// File: rtl/cnn_axi_wr_slave_ctrl.sv
// AXI3 write slave for the CNN config/weight memory: AW -> W beats -> B response, one burst at a time.
// Latency: first beat accepted the cycle after AW handshake; bvalid the cycle after the last beat.
// Backpressure: wready follows i_mem_ready (no buffering); B is held until bready; AW is refused outside IDLE.
module cnn_axi_wr_slave_ctrl #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    ID_MAX_WIDTH = 4,
    parameter logic [ADDR_WIDTH-1:0] MEM_BASE     = '0,
    parameter int                    MEM_BYTES    = 4096
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [ID_MAX_WIDTH-1:0]      awid,
    input  logic [ADDR_WIDTH-1:0]        awaddr,
    input  logic [3:0]                   awlen,
    input  logic [2:0]                   awsize,
    input  logic [1:0]                   awbrust,
    input  logic                         awvalid,
    output logic                         awready,
    input  logic [ID_MAX_WIDTH-1:0]      wid,
    input  logic [DATA_WIDTH-1:0]        wdata,
    input  logic [DATA_WIDTH/8-1:0]      wstrb,
    input  logic                         wlast,
    input  logic                         wvalid,
    output logic                         wready,
    output logic [ID_MAX_WIDTH-1:0]      bid,
    output logic [1:0]                   bresp,
    output logic                         buser,
    output logic                         bvalid,
    input  logic                         bready,
    output logic                         o_mem_we,
    output logic [$clog2(MEM_BYTES)-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0]        o_mem_wdata,
    output logic [DATA_WIDTH/8-1:0]      o_mem_be,
    input  logic                         i_mem_ready
);

    localparam int NB = DATA_WIDTH / 8;
    localparam int LB = $clog2(NB);
    localparam int MA = $clog2(MEM_BYTES);
    localparam logic [ADDR_WIDTH:0] WIN_LO = {1'b0, MEM_BASE};
    localparam logic [ADDR_WIDTH:0] WIN_HI = WIN_LO + (ADDR_WIDTH+1)'(MEM_BYTES);

    typedef enum logic [1:0] {IDLE, DATA, DRAIN, RESP} state_t;

    state_t                  state;
    logic [ID_MAX_WIDTH-1:0] id_q;
    logic [MA-1:0]           cur_off;
    logic [3:0]              len_q;
    logic [2:0]              sz_q;
    logic                    fixed_q;
    logic [3:0]              cnt;
    logic                    err_q;

    logic                    beat;
    logic                    last_beat;
    logic                    beat_err;
    logic                    aw_err;
    logic [ADDR_WIDTH:0]     aw_span;
    logic [ADDR_WIDTH:0]     aw_end;
    int                      lane_off;
    int                      lane_cnt;

    // Address-phase legality: burst type, beat size, alignment and window bounds
    always_comb begin
        if (awbrust == 2'b00)
            aw_span = (ADDR_WIDTH+1)'(1) << awsize;
        else
            aw_span = (ADDR_WIDTH+1)'(5'({1'b0, awlen}) + 5'd1) << awsize;
        aw_end = {1'b0, awaddr} + aw_span - (ADDR_WIDTH+1)'(1);
        aw_err = awbrust[1]
              || (int'(awsize) > LB)
              || ((awaddr & ((ADDR_WIDTH'(1) << awsize) - ADDR_WIDTH'(1))) != '0)
              || ({1'b0, awaddr} < WIN_LO)
              || (aw_end >= WIN_HI);
    end

    // W channel acceptance: gated by memory in DATA, unconditional while draining
    always_comb begin
        wready = 1'b0;
        case (state)
            DATA:    wready = i_mem_ready;
            DRAIN:   wready = 1'b1;
            default: wready = 1'b0;
        endcase
    end

    assign beat      = wvalid && wready;
    assign last_beat = (cnt == len_q);
    assign beat_err  = (wid != id_q) || (wlast != last_beat);

    assign o_mem_we    = (state == DATA) && beat && (wid == id_q);
    assign o_mem_addr  = cur_off & ~MA'(NB - 1);
    assign o_mem_wdata = wdata;
    assign buser       = 1'b0;

    // Byte enables: strobes restricted to the lanes the current narrow beat occupies
    always_comb begin
        lane_off = int'(cur_off) & (NB - 1);
        lane_cnt = 1 << sz_q;
        for (int i = 0; i < NB; i++)
            o_mem_be[i] = wstrb[i] && (i >= lane_off) && (i < lane_off + lane_cnt);
    end

    // Burst sequencer with registered AW/B handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            awready <= 1'b1;
            bvalid  <= 1'b0;
            bresp   <= 2'b00;
            bid     <= '0;
            id_q    <= '0;
            cur_off <= '0;
            len_q   <= '0;
            sz_q    <= '0;
            fixed_q <= 1'b0;
            cnt     <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (awvalid && awready) begin
                        id_q    <= awid;
                        cur_off <= MA'(awaddr - MEM_BASE);
                        len_q   <= awlen;
                        sz_q    <= awsize;
                        fixed_q <= (awbrust == 2'b00);
                        cnt     <= '0;
                        awready <= 1'b0;
                        err_q   <= aw_err;
                        state   <= aw_err ? DRAIN : DATA;
                    end
                end
                DATA: begin
                    if (beat) begin
                        cnt <= cnt + 4'd1;
                        if (!fixed_q)
                            cur_off <= cur_off + (MA'(1) << sz_q);
                        if (beat_err)
                            err_q <= 1'b1;
                        if (last_beat) begin
                            state  <= RESP;
                            bvalid <= 1'b1;
                            bid    <= id_q;
                            bresp  <= (err_q || beat_err) ? 2'b10 : 2'b00;
                        end
                    end
                end
                DRAIN: begin
                    if (beat) begin
                        cnt <= cnt + 4'd1;
                        if (last_beat) begin
                            state  <= RESP;
                            bvalid <= 1'b1;
                            bid    <= id_q;
                            bresp  <= 2'b10;
                        end
                    end
                end
                RESP: begin
                    if (bready) begin
                        bvalid  <= 1'b0;
                        awready <= 1'b1;
                        err_q   <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_axi_wr_slave_ctrl.sv
module tb_cnn_axi_wr_slave_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  awid = '0;
    logic [31:0] awaddr = '0;
    logic [3:0]  awlen = '0;
    logic [2:0]  awsize = '0;
    logic [1:0]  awbrust = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [3:0]  wid = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wlast = 1'b0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        buser;
    logic        bvalid;
    logic        bready = 1'b1;
    logic        o_mem_we;
    logic [11:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_be;
    logic        i_mem_ready = 1'b1;

    cnn_axi_wr_slave_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awbrust(awbrust),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .buser(buser), .bvalid(bvalid), .bready(bready),
        .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
        .o_mem_be(o_mem_be), .i_mem_ready(i_mem_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wr_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } b_t;

    wr_t exp_wr[$];
    b_t  exp_b[$];
    int  tests = 0;
    int  fails = 0;
    int  cyc = 0;
    int  aw_cyc = 0;
    int  b_cyc = 0;
    bit  tog_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory-ready toggler used by the stall test
    always @(posedge clk) begin
        if (tog_en) begin
            #1;
            i_mem_ready = ~i_mem_ready;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: pops expectations whenever the DUT writes memory or completes a B handshake
    always @(negedge clk) begin
        wr_t ew;
        b_t  eb;
        if (o_mem_we) begin
            tests++;
            if (exp_wr.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write addr=%0h data=%0h be=%0h", o_mem_addr, o_mem_wdata, o_mem_be);
            end else begin
                ew = exp_wr.pop_front();
                if (o_mem_addr !== ew.addr || o_mem_wdata !== ew.data || o_mem_be !== ew.be) begin
                    fails++;
                    $display("FAIL mem_write actual=%0h/%0h/%0h required=%0h/%0h/%0h",
                             o_mem_addr, o_mem_wdata, o_mem_be, ew.addr, ew.data, ew.be);
                end
            end
            check("we_needs_mem_ready", i_mem_ready, 1'b1);
        end
        if (bvalid && bready) begin
            b_cyc = cyc;
            tests++;
            if (exp_b.size() == 0) begin
                fails++;
                $display("FAIL unexpected_b bid=%0h bresp=%0h", bid, bresp);
            end else begin
                eb = exp_b.pop_front();
                if (bid !== eb.id || bresp !== eb.resp) begin
                    fails++;
                    $display("FAIL b_resp actual=%0h/%0h required=%0h/%0h", bid, bresp, eb.id, eb.resp);
                end
            end
        end
    end

    // All tasks start and end at posedge+1
    task automatic do_aw(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
        bit ok = 1'b0;
        awid = id; awaddr = addr; awlen = len; awsize = size; awbrust = burst; awvalid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (awready) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        aw_cyc = cyc;
        if (!ok) check("aw_timeout", 0, 1);
        @(posedge clk); #1;
        awvalid = 1'b0;
    endtask

    task automatic send_beat(input logic [3:0] id, input logic [31:0] data, input logic [3:0] strb,
                             input logic last, input bit chk_rdy);
        bit ok = 1'b0;
        wid = id; wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (chk_rdy) check("wready_follows_mem", wready, i_mem_ready);
            if (wready) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        if (!ok) check("w_timeout", 0, 1);
        @(posedge clk); #1;
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic wait_b();
        bit ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bvalid && bready) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        if (!ok) check("b_timeout", 0, 1);
        @(posedge clk); #1;
        check("awready_after_b", awready, 1'b1);
    endtask

    task automatic push_wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_t w;
        w.addr = a; w.data = d; w.be = be;
        exp_wr.push_back(w);
    endtask

    task automatic push_b(input logic [3:0] id, input logic [1:0] r);
        b_t b;
        b.id = id; b.resp = r;
        exp_b.push_back(b);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #12;
        check("rst_awready", awready, 1'b1);
        check("rst_wready", wready, 1'b0);
        check("rst_bvalid", bvalid, 1'b0);
        check("rst_bresp", bresp, 2'b00);
        check("rst_bid", bid, 4'h0);
        check("rst_mem_we", o_mem_we, 1'b0);
        check("rst_buser", buser, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // INCR 4 x 32-bit from 0x10, latency check
        for (int i = 0; i < 4; i++) push_wr(12'h010 + 12'(4*i), 32'hA000_0000 + i, 4'hF);
        push_b(4'h5, 2'b00);
        do_aw(4'h5, 32'h10, 4'd3, 3'd2, 2'b01);
        for (int i = 0; i < 4; i++) send_beat(4'h5, 32'hA000_0000 + i, 4'hF, i == 3, 1'b0);
        wait_b();
        check("b_latency", 64'(b_cyc - aw_cyc), 64'd5);

        // FIXED halfword burst, bready held low for a while
        for (int i = 0; i < 3; i++) push_wr(12'h040, 32'hB000_0000 + i, 4'b0011);
        push_b(4'h3, 2'b00);
        bready = 1'b0;
        do_aw(4'h3, 32'h40, 4'd2, 3'd1, 2'b00);
        for (int i = 0; i < 3; i++) send_beat(4'h3, 32'hB000_0000 + i, 4'hF, i == 2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bvalid_held", bvalid, 1'b1);
            @(posedge clk); #1;
        end
        bready = 1'b1;
        wait_b();

        // INCR byte burst from an unaligned-to-bus address
        push_wr(12'h020, 32'hC000_0000, 4'b0010);
        push_wr(12'h020, 32'hC000_0001, 4'b0100);
        push_wr(12'h020, 32'hC000_0002, 4'b1000);
        push_b(4'h1, 2'b00);
        do_aw(4'h1, 32'h21, 4'd2, 3'd0, 2'b01);
        for (int i = 0; i < 3; i++) send_beat(4'h1, 32'hC000_0000 + i, 4'hF, i == 2, 1'b0);
        wait_b();

        // Burst running past the end of the window: drained
        push_b(4'h7, 2'b10);
        do_aw(4'h7, 32'hFFC, 4'd1, 3'd2, 2'b01);
        for (int i = 0; i < 2; i++) send_beat(4'h7, 32'hD000_0000 + i, 4'hF, i == 1, 1'b0);
        wait_b();

        // WRAP burst type: drained
        push_b(4'h2, 2'b10);
        do_aw(4'h2, 32'h0, 4'd1, 3'd2, 2'b10);
        for (int i = 0; i < 2; i++) send_beat(4'h2, 32'hD100_0000 + i, 4'hF, i == 1, 1'b0);
        wait_b();

        // Beat wider than the bus: drained
        push_b(4'h4, 2'b10);
        do_aw(4'h4, 32'h0, 4'd0, 3'd3, 2'b01);
        send_beat(4'h4, 32'hD200_0000, 4'hF, 1'b1, 1'b0);
        wait_b();

        // Memory stalls toggling every cycle
        for (int i = 0; i < 4; i++) push_wr(12'h100 + 12'(4*i), 32'hE000_0000 + i, 4'hF);
        push_b(4'h6, 2'b00);
        do_aw(4'h6, 32'h100, 4'd3, 3'd2, 2'b01);
        tog_en = 1'b1;
        for (int i = 0; i < 4; i++) send_beat(4'h6, 32'hE000_0000 + i, 4'hF, i == 3, 1'b1);
        tog_en = 1'b0;
        #2;
        i_mem_ready = 1'b1;
        wait_b();

        // Early wlast on beat 1: all beats still written, SLVERR
        for (int i = 0; i < 4; i++) push_wr(12'h200 + 12'(4*i), 32'hF000_0000 + i, 4'hF);
        push_b(4'h9, 2'b10);
        do_aw(4'h9, 32'h200, 4'd3, 3'd2, 2'b01);
        for (int i = 0; i < 4; i++) send_beat(4'h9, 32'hF000_0000 + i, 4'hF, (i == 1) || (i == 3), 1'b0);
        wait_b();

        // Wrong wid on beat 0: that beat dropped, burst continues, SLVERR
        push_wr(12'h304, 32'h1234_0001, 4'hF);
        push_b(4'hA, 2'b10);
        do_aw(4'hA, 32'h300, 4'd1, 3'd2, 2'b01);
        send_beat(4'hB, 32'h1234_0000, 4'hF, 1'b0, 1'b0);
        send_beat(4'hA, 32'h1234_0001, 4'hF, 1'b1, 1'b0);
        wait_b();

        // Reset in the middle of a burst: no B response
        push_wr(12'h400, 32'h5500_0000, 4'hF);
        push_wr(12'h404, 32'h5500_0001, 4'hF);
        do_aw(4'hC, 32'h400, 4'd3, 3'd2, 2'b01);
        for (int i = 0; i < 2; i++) send_beat(4'hC, 32'h5500_0000 + i, 4'hF, 1'b0, 1'b0);
        wvalid = 1'b1;
        rst_n = 1'b0;
        #2;
        check("midrst_awready", awready, 1'b1);
        check("midrst_wready", wready, 1'b0);
        check("midrst_bvalid", bvalid, 1'b0);
        check("midrst_mem_we", o_mem_we, 1'b0);
        check("midrst_bid", bid, 4'h0);
        wvalid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("no_b_after_rst", bvalid, 1'b0);
            @(posedge clk); #1;
        end

        // Recovery: single beat with partial strobes
        push_wr(12'h010, 32'h7777_0000, 4'b0110);
        push_b(4'hD, 2'b00);
        do_aw(4'hD, 32'h10, 4'd0, 3'd2, 2'b01);
        send_beat(4'hD, 32'h7777_0000, 4'b0110, 1'b1, 1'b0);
        wait_b();

        repeat (3) @(posedge clk);
        check("wr_queue_empty", 64'(exp_wr.size()), 64'd0);
        check("b_queue_empty", 64'(exp_b.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
